// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: round-robin ALU/load writeback arbiter with a register busy scoreboard.
// Accepted writes reach the write port one cycle later; busy bits gate dependent issue via stall.
module regfile_wb_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    output logic        stall,
    output logic        reg_wr,
    output logic [4:0]  wr_reg,
    output logic [31:0] wr_data,
    output logic [5:0]  busy_cnt
);
    logic [31:1] busy;
    logic [31:1] busy_next;
    logic [31:0] busy_full;
    logic        alu_pri;
    logic        acc;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;
    logic [5:0]  cnt_next;

    // alu_pri set means the ALU wins the next contended cycle; reset favours MEM
    assign alu_ready = alu_valid & (~mem_valid | alu_pri);
    assign mem_ready = mem_valid & ~alu_ready;
    assign acc       = alu_ready | mem_ready;
    assign sel_rd    = alu_ready ? alu_rd : mem_rd;
    assign sel_data  = alu_ready ? alu_data : mem_data;
    assign busy_full = {busy, 1'b0};
    assign stall     = busy_full[chk_rs1] | busy_full[chk_rs2];

    // set after clear so a same-edge reissue keeps the register pending
    for (genvar i = 1; i < 32; i++) begin : g_busy
        assign busy_next[i] = (iss_valid && iss_rd == 5'(i)) |
                              (busy[i] & ~(reg_wr && wr_reg == 5'(i)));
    end

    always_comb begin
        cnt_next = '0;
        for (int k = 1; k < 32; k++) cnt_next = cnt_next + 6'(busy_next[k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
            alu_pri  <= 1'b0;
            reg_wr   <= 1'b0;
            wr_reg   <= '0;
            wr_data  <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
            if (alu_valid && mem_valid) alu_pri <= ~alu_pri;
            reg_wr   <= acc && sel_rd != 5'd0;
            if (acc) begin
                wr_reg  <= sel_rd;
                wr_data <= sel_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: per-cycle model comparison plus directed scenarios with literal expectations.
module tb_regfile_wb_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, iss_valid = 1'b0;
    logic [4:0]  alu_rd = '0, mem_rd = '0, iss_rd = '0, chk_rs1 = '0, chk_rs2 = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        alu_ready, mem_ready, stall, reg_wr;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [5:0]  busy_cnt;

    int tests = 0;
    int fails = 0;

    regfile_wb_sched dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
        .stall(stall), .reg_wr(reg_wr), .wr_reg(wr_reg), .wr_data(wr_data), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: pending set of registers, who won the last contention, and the pending write
    logic [31:0] m_busy;
    logic        m_alu_won_last;
    logic        m_wr;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        g_alu, g_mem, exp_stall;
    logic [31:0] nb;

    always_comb begin
        g_alu = alu_valid && (!mem_valid || !m_alu_won_last);
        g_mem = mem_valid && !g_alu;
        nb = m_busy;
        if (m_wr) nb[m_rd] = 1'b0;
        if (iss_valid && iss_rd != 0) nb[iss_rd] = 1'b1;
        exp_stall = (chk_rs1 != 0 && m_busy[chk_rs1]) || (chk_rs2 != 0 && m_busy[chk_rs2]);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= '0;
            m_alu_won_last <= 1'b1;
            m_wr <= 1'b0;
            m_rd <= '0;
            m_data <= '0;
        end else begin
            m_busy <= nb;
            if (alu_valid && mem_valid) m_alu_won_last <= g_alu;
            m_wr <= g_alu ? (alu_rd != 0) : g_mem ? (mem_rd != 0) : 1'b0;
            if (g_alu || g_mem) begin
                m_rd <= g_alu ? alu_rd : mem_rd;
                m_data <= g_alu ? alu_data : mem_data;
            end
        end
    end

    always @(negedge clk) begin
        check("m_alu_ready", 32'(alu_ready), 32'(g_alu));
        check("m_mem_ready", 32'(mem_ready), 32'(g_mem));
        check("m_one_grant", 32'(alu_ready & mem_ready), 32'd0);
        check("m_stall", 32'(stall), 32'(exp_stall));
        check("m_reg_wr", 32'(reg_wr), 32'(m_wr));
        check("m_busy_cnt", 32'(busy_cnt), $countones(m_busy));
        if (m_wr) begin
            check("m_wr_reg", 32'(wr_reg), 32'(m_rd));
            check("m_wr_data", wr_data, m_data);
        end
        if (rst) begin
            check("m_rst_wr_reg", 32'(wr_reg), 32'd0);
            check("m_rst_wr_data", wr_data, 32'd0);
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_reg_wr", 32'(reg_wr), 32'd0);
        check("rst_wr_reg", 32'(wr_reg), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_busy_cnt", 32'(busy_cnt), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        #10 rst = 1'b0;

        // single ALU write
        cyc;
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1 check("s1_alu_ready", 32'(alu_ready), 32'd1);
        check("s1_mem_ready", 32'(mem_ready), 32'd0);
        cyc;
        alu_valid = 0;
        check("s1_reg_wr", 32'(reg_wr), 32'd1);
        check("s1_wr_reg", 32'(wr_reg), 32'd5);
        check("s1_wr_data", wr_data, 32'hDEADBEEF);
        cyc;
        check("s1_no_wr", 32'(reg_wr), 32'd0);

        // contention: MEM, ALU, MEM, ALU
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        mem_valid = 1; mem_rd = 4; mem_data = 32'h44;
        for (int i = 0; i < 4; i++) begin
            #1 check("s2_mem_grant", 32'(mem_ready), 32'(i % 2 == 0));
            check("s2_alu_grant", 32'(alu_ready), 32'(i % 2 == 1));
            cyc;
            check("s2_wr_reg", 32'(wr_reg), (i % 2 == 0) ? 32'd4 : 32'd3);
        end
        alu_valid = 0; mem_valid = 0;
        cyc;

        // scoreboard set then load clears it
        iss_valid = 1; iss_rd = 7;
        cyc;
        iss_valid = 0; chk_rs1 = 7;
        #1 check("s3_stall", 32'(stall), 32'd1);
        check("s3_cnt", 32'(busy_cnt), 32'd1);
        mem_valid = 1; mem_rd = 7; mem_data = 32'h7777;
        #1 check("s3_mem_ready", 32'(mem_ready), 32'd1);
        cyc;
        mem_valid = 0;
        check("s3_reg_wr", 32'(reg_wr), 32'd1);
        check("s3_stall_held", 32'(stall), 32'd1);
        cyc;
        check("s3_stall_drop", 32'(stall), 32'd0);
        check("s3_cnt_zero", 32'(busy_cnt), 32'd0);
        chk_rs1 = 0;

        // same-edge set and clear on x9
        mem_valid = 1; mem_rd = 9; mem_data = 32'h9999;
        cyc;
        mem_valid = 0; iss_valid = 1; iss_rd = 9;
        check("s4_reg_wr", 32'(reg_wr), 32'd1);
        cyc;
        iss_valid = 0; chk_rs2 = 9;
        #1 check("s4_stall", 32'(stall), 32'd1);
        check("s4_cnt", 32'(busy_cnt), 32'd1);
        alu_valid = 1; alu_rd = 9; alu_data = 32'h1;
        cyc;
        alu_valid = 0;
        cyc;
        check("s4_cleared", 32'(busy_cnt), 32'd0);
        chk_rs2 = 0;

        // x0 writes and issues are invisible
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF; iss_valid = 1; iss_rd = 0;
        #1 check("s5_alu_ready", 32'(alu_ready), 32'd1);
        cyc;
        alu_valid = 0; iss_valid = 0;
        check("s5_reg_wr", 32'(reg_wr), 32'd0);
        check("s5_cnt", 32'(busy_cnt), 32'd0);
        #1 check("s5_stall", 32'(stall), 32'd0);

        // leave the pointer favouring ALU: contention won by MEM, then ALU alone
        alu_valid = 1; alu_rd = 20; alu_data = 32'h20;
        mem_valid = 1; mem_rd = 21; mem_data = 32'h21;
        #1 check("s6_mem_first", 32'(mem_ready), 32'd1);
        cyc;
        mem_valid = 0;
        cyc;
        alu_valid = 0;

        // async reset with three pending registers and a write in flight
        iss_valid = 1; iss_rd = 10;
        cyc;
        iss_rd = 11;
        cyc;
        iss_rd = 12; alu_valid = 1; alu_rd = 13; alu_data = 32'hABCD;
        cyc;
        iss_valid = 0; alu_valid = 0; chk_rs1 = 10;
        check("s6_cnt3", 32'(busy_cnt), 32'd3);
        check("s6_pending", 32'(reg_wr), 32'd1);
        #1 rst = 1;
        #1 check("s6_rst_wr", 32'(reg_wr), 32'd0);
        check("s6_rst_reg", 32'(wr_reg), 32'd0);
        check("s6_rst_data", wr_data, 32'd0);
        check("s6_rst_cnt", 32'(busy_cnt), 32'd0);
        check("s6_rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #3 rst = 0;
        cyc;
        check("s6_no_wr", 32'(reg_wr), 32'd0);
        alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
        mem_valid = 1; mem_rd = 2; mem_data = 32'h2;
        #1 check("s6_ptr_reset", 32'(mem_ready), 32'd1);
        cyc;
        mem_valid = 0;
        cyc;
        alu_valid = 0;
        cyc;
        cyc;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_wb_sched.md
REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  – rising-edge clock
- rst  in  1  – asynchronous, active-high reset
- alu_valid  in  1  – ALU writeback request
- alu_rd  in  5  – ALU destination register
- alu_data  in  32  – ALU result
- alu_ready  out  1  – ALU request accepted this cycle
- mem_valid  in  1  – load writeback request
- mem_rd  in  5  – load destination register
- mem_data  in  32  – load data
- mem_ready  out  1  – load request accepted this cycle
- iss_valid  in  1  – instruction issued with destination
- iss_rd  in  5  – issued destination register
- chk_rs1  in  5  – source register 1 to check
- chk_rs2  in  5  – source register 2 to check
- stall  out  1  – a source is pending
- reg_wr  out  1  – register-file write enable
- wr_reg  out  5  – register-file write address
- wr_data  out  32  – register-file write data
- busy_cnt  out  6  – number of pending registers

Function
REQ-002 The block SHALL share the single register-file write port between the ALU and MEM requesters, granting at most one per cycle.
REQ-003 alu_ready and mem_ready SHALL be combinational and never asserted together.
- Only one valid: that requester is granted.
- Both valid: round-robin; grant the requester not granted last time.
REQ-004 The round-robin pointer SHALL update only on a cycle where both requesters are valid.
- Reset value: MEM has priority.
REQ-005 A requester SHALL hold valid, rd and data stable until its ready is seen high; maximum wait under contention is 1 cycle.
REQ-006 On an accept edge, reg_wr, wr_reg and wr_data SHALL register the granted request.
- Fixed latency of 1 cycle from accept to write-port presentation.
- reg_wr SHALL be 0 in cycles following no accept.
REQ-007 A granted request with rd = 0 SHALL be accepted (ready = 1) but SHALL produce reg_wr = 0.
REQ-008 A scoreboard busy[31:1] SHALL be maintained; busy[0] SHALL read as 0 permanently.
REQ-009 At a rising edge with iss_valid = 1 and iss_rd != 0, busy[iss_rd] SHALL be set.
REQ-010 At a rising edge with reg_wr = 1, busy[wr_reg] SHALL be cleared.
- This is the same edge on which the register file commits the write.
REQ-011 If set and clear target the same register at the same edge, set SHALL win (a newer producer is pending).
REQ-012 stall SHALL be combinational: busy[chk_rs1] OR busy[chk_rs2].
- Because busy[0] is always 0, x0 never stalls.
REQ-013 busy_cnt SHALL be a registered population count of busy[31:1] as of the current state (range 0..31).
REQ-014 A write to a non-busy register SHALL be permitted, with no error and no scoreboard change.
REQ-015 The block SHALL not inspect or modify write data.

Reset
REQ-016 While rst = 1, regardless of clk, the following SHALL hold:
- reg_wr = 0, wr_reg = 0, wr_data = 0
- all busy bits = 0, busy_cnt = 0
- round-robin pointer = MEM priority
REQ-017 After reset, alu_ready, mem_ready and stall SHALL follow their combinational definitions from the cleared state.
REQ-018 Reset asserted mid-operation SHALL discard any registered write, so that no reg_wr pulse appears after rst deasserts.
- Writes already committed to the register file are unaffected.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- Reset, then alu_valid = 1, rd = 5, data = 0xDEADBEEF -> alu_ready = 1 that cycle; next cycle reg_wr = 1, wr_reg = 5, wr_data = 0xDEADBEEF.
- Both requesters valid for 4 cycles (alu rd = 3, mem rd = 4), each held until accepted and then re-presented -> grant order MEM, ALU, MEM, ALU; never both ready in one cycle.
- iss_valid, iss_rd = 7; next cycle chk_rs1 = 7 -> stall = 1, busy_cnt = 1; mem write rd = 7 accepted -> stall drops the cycle after reg_wr = 1, busy_cnt = 0.
- Same-edge set/clear: reg_wr to rd = 9 while iss_valid with iss_rd = 9 -> busy[9] remains 1, stall = 1 for chk_rs2 = 9.
- alu rd = 0 with iss_rd = 0 -> alu_ready = 1, reg_wr stays 0, busy_cnt stays 0, stall = 0 for chk_rs1 = 0.
- rst pulsed asynchronously mid-cycle with busy_cnt = 3 and a write pending in the output register -> outputs cleared immediately; no reg_wr after release; busy_cnt = 0.
